// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects
// and the load-use detection rule.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  function automatic logic load_use_hazard(
    input logic       exLoad,
    input logic [4:0] exRt,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       usesRs,
    input logic       usesRt
  );
    return exLoad && (exRt != 5'd0) &&
           ((usesRs && (idRs == exRt)) || (usesRt && (idRt == exRt)));
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Per-operand forwarding select: MEM result wins over WB, register 0 never forwarded.
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       i_enable,
  input  logic [4:0] i_srcAddr,
  input  logic       i_memRegWrite,
  input  logic [4:0] i_memDstAddr,
  input  logic       i_wbRegWrite,
  input  logic [4:0] i_wbDstAddr,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_NONE;
    if (i_enable) begin
      if (i_memRegWrite && (i_memDstAddr != '0) && (i_memDstAddr == i_srcAddr)) begin
        o_sel = FWD_MEM;
      end else if (i_wbRegWrite && (i_wbDstAddr != '0) && (i_wbDstAddr == i_srcAddr)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: post-reset flush, load-use bubble, branch/jump flush,
// data-memory freeze with sticky timeout, forwarding. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  idRsAddr_i,
  input  logic [4:0]  idRtAddr_i,
  input  logic        idUsesRs_i,
  input  logic        idUsesRt_i,
  input  logic [4:0]  exRsAddr_i,
  input  logic [4:0]  exRtAddr_i,
  input  logic        exMemToRead_i,
  input  logic        branchTaken_i,
  input  logic        exJump_i,
  input  logic        memRegWrite_i,
  input  logic [4:0]  memDstAddr_i,
  input  logic        wbRegWrite_i,
  input  logic [4:0]  wbDstAddr_i,
  input  logic        dmemReq_i,
  input  logic        dmemReady_i,
  output logic        pcWrite_o,
  output logic        ifidWrite_o,
  output logic        ifidFlush_o,
  output logic        deWrite_o,
  output logic        deFlush_o,
  output logic        emWrite_o,
  output logic        mwWrite_o,
  output logic [1:0]  forwardA_o,
  output logic [1:0]  forwardB_o,
  output logic        memTimeout_o,
  output logic [1:0]  state_o,
  output logic [31:0] stallCycles_o,
  output logic [31:0] flushCount_o,
  output logic [31:0] memWaitCycles_o
);

  localparam int unsigned ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

  state_e         r_state;
  logic [ICW-1:0] r_initCnt;
  logic [WCW-1:0] r_waitCnt;
  logic           r_memTimeout;

  logic w_init;
  logic w_frozen;
  logic w_flush;
  logic w_loadUse;

  // Reset forces the INIT output pattern combinationally, before the state register catches up.
  assign w_init = (r_state == ST_INIT) || !rst_ni;

  always_comb begin
    w_frozen = 1'b0;
    case (r_state)
      ST_RUN:      w_frozen = dmemReq_i && !dmemReady_i;
      ST_MEM_WAIT: w_frozen = !dmemReady_i;
      default:     w_frozen = 1'b0;
    endcase
    if (w_init) w_frozen = 1'b0;
  end

  assign w_flush   = !w_init && !w_frozen && (branchTaken_i || exJump_i);
  assign w_loadUse = !w_init && !w_frozen && !w_flush &&
                     load_use_hazard(exMemToRead_i, exRtAddr_i, idRsAddr_i, idRtAddr_i,
                                     idUsesRs_i, idUsesRt_i);

  assign pcWrite_o    = !w_init && !w_frozen && !w_loadUse;
  assign ifidWrite_o  = w_init || (!w_frozen && !w_loadUse);
  assign ifidFlush_o  = w_init || w_flush;
  assign deWrite_o    = !w_frozen;
  assign deFlush_o    = w_init || w_flush || w_loadUse;
  assign emWrite_o    = !w_frozen;
  assign mwWrite_o    = !w_frozen;
  assign memTimeout_o = r_memTimeout;
  assign state_o      = r_state;

  forward_unit u_fwd_a (
    .i_enable      (!w_init),
    .i_srcAddr     (exRsAddr_i),
    .i_memRegWrite (memRegWrite_i),
    .i_memDstAddr  (memDstAddr_i),
    .i_wbRegWrite  (wbRegWrite_i),
    .i_wbDstAddr   (wbDstAddr_i),
    .o_sel         (forwardA_o)
  );

  forward_unit u_fwd_b (
    .i_enable      (!w_init),
    .i_srcAddr     (exRtAddr_i),
    .i_memRegWrite (memRegWrite_i),
    .i_memDstAddr  (memDstAddr_i),
    .i_wbRegWrite  (wbRegWrite_i),
    .i_wbDstAddr   (wbDstAddr_i),
    .o_sel         (forwardB_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= ST_INIT;
      r_initCnt    <= '0;
      r_waitCnt    <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_initCnt == ICW'(INIT_CYCLES - 1)) r_state <= ST_RUN;
          else r_initCnt <= r_initCnt + 1'b1;
        end
        ST_RUN, ST_MEM_WAIT: r_state <= w_frozen ? ST_MEM_WAIT : ST_RUN;
        default: r_state <= ST_INIT;
      endcase
      // Wait counter saturates at MEM_TIMEOUT; the flag stays set while the FSM keeps waiting.
      if (w_frozen) begin
        if (r_waitCnt != WCW'(MEM_TIMEOUT)) r_waitCnt <= r_waitCnt + 1'b1;
        if (r_waitCnt >= WCW'(MEM_TIMEOUT - 1)) r_memTimeout <= 1'b1;
      end else begin
        r_waitCnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_flushCount;
  logic [31:0] r_memWaitCycles;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stallCycles   <= '0;
      r_flushCount    <= '0;
      r_memWaitCycles <= '0;
    end else if (!w_init) begin
      if (w_loadUse) r_stallCycles   <= r_stallCycles + 32'd1;
      if (w_flush)   r_flushCount    <= r_flushCount + 32'd1;
      if (w_frozen)  r_memWaitCycles <= r_memWaitCycles + 32'd1;
    end
  end

  assign stallCycles_o   = r_stallCycles;
  assign flushCount_o    = r_flushCount;
  assign memWaitCycles_o = r_memWaitCycles;
`else
  assign stallCycles_o   = '0;
  assign flushCount_o    = '0;
  assign memWaitCycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned MEM_TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       usesRs;
    logic       usesRt;
    logic [4:0] exRs;
    logic [4:0] exRt;
    logic       load;
    logic       br;
    logic       jmp;
    logic       memRw;
    logic [4:0] memDst;
    logic       wbRw;
    logic [4:0] wbDst;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    string       name;
    in_t         i;
    logic [10:0] e;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  idRsAddr, idRtAddr, exRsAddr, exRtAddr, memDstAddr, wbDstAddr;
  logic        idUsesRs, idUsesRt, exMemToRead, branchTaken, exJump;
  logic        memRegWrite, wbRegWrite, dmemReq, dmemReady;
  logic        pcWrite, ifidWrite, ifidFlush, deWrite, deFlush, emWrite, mwWrite;
  logic [1:0]  forwardA, forwardB, state;
  logic        memTimeout;
  logic [31:0] stallCycles, flushCount, memWaitCycles;
  logic [10:0] ctrl;

  assign ctrl = {pcWrite, ifidWrite, ifidFlush, deWrite, deFlush, emWrite, mwWrite,
                 forwardA, forwardB};

  pipeline_hazard_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .idRsAddr_i      (idRsAddr),
    .idRtAddr_i      (idRtAddr),
    .idUsesRs_i      (idUsesRs),
    .idUsesRt_i      (idUsesRt),
    .exRsAddr_i      (exRsAddr),
    .exRtAddr_i      (exRtAddr),
    .exMemToRead_i   (exMemToRead),
    .branchTaken_i   (branchTaken),
    .exJump_i        (exJump),
    .memRegWrite_i   (memRegWrite),
    .memDstAddr_i    (memDstAddr),
    .wbRegWrite_i    (wbRegWrite),
    .wbDstAddr_i     (wbDstAddr),
    .dmemReq_i       (dmemReq),
    .dmemReady_i     (dmemReady),
    .pcWrite_o       (pcWrite),
    .ifidWrite_o     (ifidWrite),
    .ifidFlush_o     (ifidFlush),
    .deWrite_o       (deWrite),
    .deFlush_o       (deFlush),
    .emWrite_o       (emWrite),
    .mwWrite_o       (mwWrite),
    .forwardA_o      (forwardA),
    .forwardB_o      (forwardB),
    .memTimeout_o    (memTimeout),
    .state_o         (state),
    .stallCycles_o   (stallCycles),
    .flushCount_o    (flushCount),
    .memWaitCycles_o (memWaitCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles left in the post-reset flush, whether the memory stage is
  // stalled, how long it has been stalled, and event tallies.
  int          m_init_left;
  bit          m_wait;
  int unsigned m_wcnt;
  bit          m_to;
  int unsigned m_stall, m_flush, m_mwc;

  int n_chk;
  int n_pass;
  in_t cur;

  function automatic bit lu_hit(in_t x);
    return x.load && (x.exRt != 5'd0) &&
           ((x.usesRs && x.idRs == x.exRt) || (x.usesRt && x.idRt == x.exRt));
  endfunction

  function automatic logic [1:0] fwd_ref(logic [4:0] src, in_t x);
    if (x.memRw && x.memDst != 5'd0 && x.memDst == src) return 2'b10;
    if (x.wbRw && x.wbDst != 5'd0 && x.wbDst == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_frozen(in_t x);
    return m_wait ? !x.rdy : (x.req && !x.rdy);
  endfunction

  function automatic logic [10:0] ref_ctrl(in_t x, logic r);
    bit fz, fl, lu;
    if (!r || m_init_left > 0) return 11'b0111111_00_00;
    fz = m_frozen(x);
    fl = !fz && (x.br || x.jmp);
    lu = !fz && !fl && lu_hit(x);
    return {!fz && !lu, !fz && !lu, fl, !fz, fl || lu, !fz, !fz,
            fwd_ref(x.exRs, x), fwd_ref(x.exRt, x)};
  endfunction

  function automatic logic [1:0] ref_state();
    if (m_init_left > 0) return 2'd0;
    return m_wait ? 2'd2 : 2'd1;
  endfunction

  task automatic model_tick(in_t x, logic r);
    bit fz, fl, lu;
    if (!r) begin
      m_init_left = INIT_CYCLES;
      m_wait = 0; m_wcnt = 0; m_to = 0;
      m_stall = 0; m_flush = 0; m_mwc = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      fz = m_frozen(x);
      fl = !fz && (x.br || x.jmp);
      lu = !fz && !fl && lu_hit(x);
      if (fz) begin
        m_wcnt++;
        if (m_wcnt >= MEM_TIMEOUT) m_to = 1;
        m_mwc++;
      end else begin
        m_wcnt = 0;
      end
      if (fl) m_flush++;
      if (lu) m_stall++;
      m_wait = fz;
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic apply(in_t x, logic r);
    cur = x;
    rst_n = r;
    idRsAddr = x.idRs; idRtAddr = x.idRt; idUsesRs = x.usesRs; idUsesRt = x.usesRt;
    exRsAddr = x.exRs; exRtAddr = x.exRt; exMemToRead = x.load;
    branchTaken = x.br; exJump = x.jmp;
    memRegWrite = x.memRw; memDstAddr = x.memDst;
    wbRegWrite = x.wbRw; wbDstAddr = x.wbDst;
    dmemReq = x.req; dmemReady = x.rdy;
    #2;
  endtask

  task automatic check_model();
    chk("ctrl_model", 32'(ctrl), 32'(ref_ctrl(cur, rst_n)));
    chk("timeout_model", 32'(memTimeout), 32'(m_to));
    chk("state_model", 32'(state), 32'(ref_state()));
    chk("stall_cnt", stallCycles, PERF ? m_stall : 32'd0);
    chk("flush_cnt", flushCount, PERF ? m_flush : 32'd0);
    chk("memwait_cnt", memWaitCycles, PERF ? m_mwc : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_tick(cur, rst_n);
  endtask

  task automatic cyc(in_t x, logic r);
    apply(x, r);
    check_model();
    tick();
  endtask

  function automatic in_t idle();
    in_t x;
    x = '0;
    x.rdy = 1'b1;
    return x;
  endfunction

  function automatic vec_t mkv(string n, in_t i, logic [10:0] e);
    vec_t v;
    v.name = n; v.i = i; v.e = e;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    in_t  t;
    n_chk = 0;
    n_pass = 0;

    t = idle();                                                 tbl.push_back(mkv("idle", t, 11'b1101011_00_00));
    t = idle(); t.load = 1; t.exRt = 8; t.usesRs = 1; t.idRs = 8; tbl.push_back(mkv("lu_rs", t, 11'b0001111_00_00));
    t = idle(); t.load = 1; t.exRt = 9; t.usesRt = 1; t.idRt = 9; tbl.push_back(mkv("lu_rt", t, 11'b0001111_00_00));
    t = idle(); t.load = 1; t.exRt = 0; t.usesRs = 1; t.idRs = 0; tbl.push_back(mkv("lu_r0", t, 11'b1101011_00_00));
    t = idle(); t.load = 1; t.exRt = 8; t.usesRs = 0; t.idRs = 8; tbl.push_back(mkv("lu_unused", t, 11'b1101011_00_00));
    t = idle(); t.load = 0; t.exRt = 8; t.usesRs = 1; t.idRs = 8; tbl.push_back(mkv("no_load", t, 11'b1101011_00_00));
    t = idle(); t.br = 1;                                       tbl.push_back(mkv("branch", t, 11'b1111111_00_00));
    t = idle(); t.jmp = 1; t.load = 1; t.exRt = 8; t.usesRs = 1; t.idRs = 8;
                                                                tbl.push_back(mkv("jump_over_lu", t, 11'b1111111_00_00));
    t = idle(); t.req = 1; t.rdy = 1;                           tbl.push_back(mkv("req_ready", t, 11'b1101011_00_00));
    t = idle(); t.memRw = 1; t.memDst = 5; t.wbRw = 1; t.wbDst = 5; t.exRs = 5;
                                                                tbl.push_back(mkv("fwd_mem_wins", t, 11'b1101011_10_00));
    t = idle(); t.memRw = 1; t.memDst = 0; t.wbRw = 1; t.wbDst = 0; t.exRs = 0;
                                                                tbl.push_back(mkv("fwd_r0", t, 11'b1101011_00_00));
    t = idle(); t.wbRw = 1; t.wbDst = 7; t.exRt = 7;            tbl.push_back(mkv("fwd_wb_b", t, 11'b1101011_00_01));
    t = idle(); t.memRw = 1; t.memDst = 3; t.exRt = 3; t.wbRw = 1; t.wbDst = 4; t.exRs = 4;
                                                                tbl.push_back(mkv("fwd_split", t, 11'b1101011_01_10));
    t = idle(); t.memRw = 0; t.memDst = 6; t.exRs = 6;          tbl.push_back(mkv("fwd_nowrite", t, 11'b1101011_00_00));

    // Power-up reset, then one checked reset cycle.
    apply(idle(), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_tick(cur, 1'b0);
    cyc(idle(), 1'b0);

    for (int k = 0; k < 4; k++) begin
      apply(idle(), 1'b1);
      chk("init_pcwrite", 32'(pcWrite), 32'd0);
      chk("init_ifidflush", 32'(ifidFlush), 32'd1);
      chk("init_deflush", 32'(deFlush), 32'd1);
      chk("init_state", 32'(state), 32'd0);
      check_model();
      tick();
    end
    apply(idle(), 1'b1);
    chk("run_state", 32'(state), 32'd1);
    chk("run_defaults", 32'(ctrl), 32'(11'b1101011_00_00));
    check_model();
    tick();

    foreach (tbl[n]) begin
      apply(tbl[n].i, 1'b1);
      chk(tbl[n].name, 32'(ctrl), 32'(tbl[n].e));
      check_model();
      tick();
    end

    // Load-use bubble lasts one cycle once the load moves on.
    t = idle(); t.load = 1; t.exRt = 8; t.usesRs = 1; t.idRs = 8;
    apply(t, 1'b1);
    chk("lu_bubble", 32'(ctrl), 32'(11'b0001111_00_00));
    check_model(); tick();
    apply(idle(), 1'b1);
    chk("lu_after", 32'(ctrl), 32'(11'b1101011_00_00));
    check_model(); tick();

    // Branch held across a 3-cycle memory freeze is flushed on the release cycle.
    t = idle(); t.req = 1; t.rdy = 0; t.br = 1;
    for (int k = 0; k < 3; k++) begin
      apply(t, 1'b1);
      chk("freeze_ctrl", 32'(ctrl), 32'(11'b0000000_00_00));
      chk("freeze_state", 32'(state), (k == 0) ? 32'd1 : 32'd2);
      check_model(); tick();
    end
    t.rdy = 1;
    apply(t, 1'b1);
    chk("release_flush", 32'(ctrl), 32'(11'b1111111_00_00));
    check_model(); tick();
    apply(idle(), 1'b1);
    chk("release_state", 32'(state), 32'd1);
    check_model(); tick();

    // Ready withheld for 6 cycles: timeout visible after the 4th frozen cycle, sticky.
    t = idle(); t.req = 1; t.rdy = 0;
    for (int k = 0; k < 6; k++) begin
      apply(t, 1'b1);
      chk("timeout_seq", 32'(memTimeout), (k >= 4) ? 32'd1 : 32'd0);
      check_model(); tick();
    end
    apply(idle(), 1'b1);
    chk("timeout_sticky", 32'(memTimeout), 32'd1);
    check_model(); tick();
    apply(idle(), 1'b1);
    chk("timeout_sticky2", 32'(memTimeout), 32'd1);
    check_model(); tick();
    cyc(idle(), 1'b0);
    apply(idle(), 1'b1);
    chk("timeout_cleared", 32'(memTimeout), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    check_model(); tick();
    for (int k = 0; k < 3; k++) cyc(idle(), 1'b1);

    // Counter scenario: two load-use bubbles and one jump since the last reset.
    t = idle(); t.load = 1; t.exRt = 8; t.usesRt = 1; t.idRt = 8;
    cyc(t, 1'b1);
    cyc(idle(), 1'b1);
    cyc(t, 1'b1);
    cyc(idle(), 1'b1);
    t = idle(); t.jmp = 1;
    cyc(t, 1'b1);
    apply(idle(), 1'b1);
    chk("perf_stall", stallCycles, PERF ? 32'd2 : 32'd0);
    chk("perf_flush", flushCount, PERF ? 32'd1 : 32'd0);
    chk("perf_memwait", memWaitCycles, 32'd0);
    check_model(); tick();

    // Reset in the middle of a memory wait abandons it.
    t = idle(); t.req = 1; t.rdy = 0;
    cyc(t, 1'b1);
    cyc(t, 1'b1);
    cyc(t, 1'b0);
    apply(t, 1'b1);
    chk("midwait_reset_state", 32'(state), 32'd0);
    check_model(); tick();

    for (int k = 0; k < 800; k++) begin
      t.idRs   = 5'($urandom_range(3));
      t.idRt   = 5'($urandom_range(3));
      t.usesRs = 1'($urandom_range(1));
      t.usesRt = 1'($urandom_range(1));
      t.exRs   = 5'($urandom_range(3));
      t.exRt   = 5'($urandom_range(3));
      t.load   = ($urandom_range(9) < 4);
      t.br     = ($urandom_range(9) == 0);
      t.jmp    = ($urandom_range(19) == 0);
      t.memRw  = 1'($urandom_range(1));
      t.memDst = 5'($urandom_range(3));
      t.wbRw   = 1'($urandom_range(1));
      t.wbDst  = 5'($urandom_range(3));
      t.req    = ($urandom_range(9) < 3);
      t.rdy    = 1'($urandom_range(1));
      cyc(t, ($urandom_range(99) == 0) ? 1'b0 : 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
